// File: rtl/writeback_seq_24b.sv
// rtl/writeback_seq_24b.sv - writeback sequencer turning results into register-file write strobes
// A 48-bit product is written as two 24-bit halves on consecutive cycles.
module writeback_seq_24b #(
  parameter int ADDR_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Valid,
  output logic              Ready,
  input  logic [2:0]        S,
  input  logic [23:0]       Dalja_nga_ALU,
  input  logic [47:0]       Dalja_nga_MUL,
  input  logic [ADDR_W-1:0] RD,
  input  logic              RegWrite,
  output logic              WE,
  output logic [ADDR_W-1:0] WAddr,
  output logic [23:0]       WData,
  output logic              Gabim,
  output logic [15:0]       Nr_Shkrimeve
);

  typedef enum logic {IDLE, WR_HI} state_t;

  localparam logic [2:0] S_MUL     = 3'b100;
  localparam logic [2:0] S_ILLEGAL = 3'b111;

  state_t              state;
  logic [ADDR_W-1:0]   hi_addr;
  logic [23:0]         hi_data;

  assign Ready = (state == IDLE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      WE           <= 1'b0;
      WAddr        <= '0;
      WData        <= '0;
      Gabim        <= 1'b0;
      Nr_Shkrimeve <= '0;
      hi_addr      <= '0;
      hi_data      <= '0;
    end else begin
      WE <= 1'b0;
      case (state)
        IDLE: begin
          if (Valid) begin
            // Illegal select wins over RegWrite: flag it, never write.
            if (S == S_ILLEGAL) begin
              Gabim <= 1'b1;
            end else if (RegWrite) begin
              WE           <= 1'b1;
              WAddr        <= RD;
              Nr_Shkrimeve <= Nr_Shkrimeve + 16'd1;
              if (S == S_MUL) begin
                WData   <= Dalja_nga_MUL[23:0];
                hi_data <= Dalja_nga_MUL[47:24];
                hi_addr <= RD + 1'b1;
                state   <= WR_HI;
              end else begin
                WData <= Dalja_nga_ALU;
              end
            end
          end
        end
        WR_HI: begin
          WE           <= 1'b1;
          WAddr        <= hi_addr;
          WData        <= hi_data;
          Nr_Shkrimeve <= Nr_Shkrimeve + 16'd1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_seq_24b.sv
// tb/tb_writeback_seq_24b.sv - randomized self-checking bench for writeback_seq_24b
module tb_writeback_seq_24b;

  logic        Clock = 1'b0;
  logic        Reset, Valid, RegWrite;
  logic        Ready, WE, Gabim;
  logic [2:0]  S;
  logic [23:0] Dalja_nga_ALU, WData;
  logic [47:0] Dalja_nga_MUL;
  logic [3:0]  RD, WAddr;
  logic [15:0] Nr_Shkrimeve;

  writeback_seq_24b #(.ADDR_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Valid(Valid), .Ready(Ready), .S(S),
    .Dalja_nga_ALU(Dalja_nga_ALU), .Dalja_nga_MUL(Dalja_nga_MUL), .RD(RD),
    .RegWrite(RegWrite), .WE(WE), .WAddr(WAddr), .WData(WData),
    .Gabim(Gabim), .Nr_Shkrimeve(Nr_Shkrimeve)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of pending register writes, one drained per cycle.
  logic [27:0] wq[$];
  logic        m_we, m_gab;
  logic [3:0]  m_addr;
  logic [23:0] m_data;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [2:0] s, input logic [23:0] alu,
                       input logic [47:0] mul, input logic [3:0] rd, input logic rw,
                       input logic rst);
    logic [3:0]  rd1;
    logic [27:0] w;
    Valid = v; S = s; Dalja_nga_ALU = alu; Dalja_nga_MUL = mul;
    RD = rd; RegWrite = rw; Reset = rst;
    @(posedge Clock);
    if (rst) begin
      wq.delete();
      m_we = 0; m_addr = 0; m_data = 0; m_gab = 0; m_cnt = 0;
    end else begin
      if (v && wq.size() == 0) begin
        if (s == 3'b111) m_gab = 1;
        else if (rw) begin
          if (s == 3'b100) begin
            rd1 = rd + 4'd1;
            wq.push_back({rd, mul[23:0]});
            wq.push_back({rd1, mul[47:24]});
          end else begin
            wq.push_back({rd, alu});
          end
        end
      end
      if (wq.size() > 0) begin
        w = wq.pop_front();
        m_we = 1; m_addr = w[27:24]; m_data = w[23:0]; m_cnt = m_cnt + 16'd1;
      end else begin
        m_we = 0;
      end
    end
    @(negedge Clock);
    check("WE", WE, m_we);
    check("WAddr", WAddr, m_addr);
    check("WData", WData, m_data);
    check("Ready", Ready, wq.size() == 0);
    check("Gabim", Gabim, m_gab);
    check("Nr_Shkrimeve", Nr_Shkrimeve, m_cnt);
  endtask

  initial begin
    m_we = 0; m_addr = 0; m_data = 0; m_gab = 0; m_cnt = 0;
    // Reset with Valid held high
    cycle(1, 3'b000, 24'h111111, 48'h0, 4'd1, 1, 1);
    cycle(1, 3'b000, 24'h111111, 48'h0, 4'd1, 1, 1);
    // Back-to-back ALU writes
    cycle(1, 3'b000, 24'h123456, 48'hDEAD_BEEF_0000, 4'd3, 1, 0);
    check("b2b_addr0", WAddr, 4'd3);
    check("b2b_data0", WData, 24'h123456);
    cycle(1, 3'b110, 24'hABCDEF, 48'h0, 4'd4, 1, 0);
    check("b2b_addr1", WAddr, 4'd4);
    check("b2b_data1", WData, 24'hABCDEF);
    check("b2b_count", Nr_Shkrimeve, 16'd2);
    // Multiply split, ALU op held through the busy cycle
    cycle(1, 3'b100, 24'h555555, 48'h0000FF_FFFF01, 4'd6, 1, 0);
    check("mul_lo", {WAddr, WData}, {4'd6, 24'hFFFF01});
    check("mul_busy", Ready, 1'b0);
    cycle(1, 3'b001, 24'h0A0B0C, 48'h0, 4'd9, 1, 0);
    check("mul_hi", {WAddr, WData}, {4'd7, 24'h0000FF});
    cycle(1, 3'b001, 24'h0A0B0C, 48'h0, 4'd9, 1, 0);
    check("held_alu", {WAddr, WData}, {4'd9, 24'h0A0B0C});
    // Address wrap
    cycle(1, 3'b100, 24'h0, 48'h111111_222222, 4'd15, 1, 0);
    cycle(0, 3'b000, 24'h0, 48'h0, 4'd0, 0, 0);
    check("wrap_hi", {WAddr, WData}, {4'd0, 24'h111111});
    // Illegal select, then no-write product
    cycle(1, 3'b111, 24'h777777, 48'h0, 4'd2, 1, 0);
    cycle(1, 3'b100, 24'h0, 48'h123456_789ABC, 4'd5, 0, 0);
    cycle(1, 3'b010, 24'h424242, 48'h0, 4'd8, 1, 0);
    check("gabim_sticky", Gabim, 1'b1);
    // Reset during the high-half cycle
    cycle(1, 3'b100, 24'h0, 48'hAAAAAA_BBBBBB, 4'd10, 1, 0);
    cycle(0, 3'b000, 24'h0, 48'h0, 4'd0, 0, 1);
    check("rst_mid_cnt", Nr_Shkrimeve, 16'd0);
    cycle(0, 3'b000, 24'h0, 48'h0, 4'd0, 0, 0);
    check("rst_mid_we", WE, 1'b0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, 3'($urandom), 24'($urandom),
            {16'($urandom), 32'($urandom)}, 4'($urandom),
            $urandom_range(0, 7) != 0, $urandom_range(0, 199) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_seq_24b.md
# writeback_seq_24b

Writeback sequencer for the 24-bit CPU. It sits directly downstream of the result-select mux and consumes its two outputs: the 24-bit ALU/load result and the 48-bit multiplier result. It turns each accepted result into register-file write strobes. A 48-bit product is split into two consecutive 24-bit writes, low half to `RD` and high half to `RD+1`, and upstream is back-pressured while the second write is in flight.

## Interface
- `ADDR_W`, default 4: register-file address width (16 registers).
- `Clock`, in, 1: sole clock; all state updates on the rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `Valid`, in, 1: upstream result and controls are valid this cycle.
- `Ready`, out, 1: block can accept this cycle. A transfer occurs when `Valid && Ready`.
- `S`, in, 3: operation select, the same code that drives the result mux.
- `Dalja_nga_ALU`, in, 24: 24-bit result.
- `Dalja_nga_MUL`, in, 48: 48-bit product.
- `RD`, in, ADDR_W: destination register.
- `RegWrite`, in, 1: the instruction writes a register.
- `WE`, out, 1: register-file write enable (registered).
- `WAddr`, out, ADDR_W: write address (registered).
- `WData`, out, 24: write data (registered).
- `Gabim`, out, 1: sticky flag; an illegal `S` (3'b111) was accepted.
- `Nr_Shkrimeve`, out, 16: count of `WE` pulses issued, wrapping.

## Operation
- FSM states:
  - `IDLE`: `Ready`=1.
  - `WR_HI`: `Ready`=0; the high half of a product is pending.
- Transfer in `IDLE` with `RegWrite`=1:
  - `S` in {000, 001, 010, 011, 101, 110}: next cycle `WE`=1, `WAddr`=`RD`, `WData`=`Dalja_nga_ALU`. State stays `IDLE`.
  - `S`=100: next cycle `WE`=1, `WAddr`=`RD`, `WData`=`Dalja_nga_MUL[23:0]`. Latch `Dalja_nga_MUL[47:24]` and `RD+1` internally. Go to `WR_HI`.
- In `WR_HI`: next cycle `WE`=1, `WAddr`=latched `RD+1`, `WData`=latched high half. Return to `IDLE`.
- Transfer with `RegWrite`=0: accepted and discarded. Next cycle `WE`=0, no state change, no `WR_HI` even when `S`=100.
- Transfer with `S`=111: accepted, no write, `WE`=0 next cycle. `Gabim` is set and holds until reset. This applies regardless of `RegWrite`.
- `RD+1` is computed modulo 2^ADDR_W. `RD`=15 puts the high half in register 0.
- `Dalja_nga_MUL` is ignored unless `S`=100, and `Dalja_nga_ALU` is ignored when `S`=100.
- When no transfer occurs (`Valid`=0, or `Valid`=1 while `Ready`=0), the next `WE`=0. `WAddr`/`WData` hold their last values.
- In `WR_HI`, `Valid`=1 is not consumed. Upstream must hold its data until `Ready` returns.
- `Nr_Shkrimeve` increments by 1 on every cycle in which `WE` is registered as 1. It wraps from 0xFFFF to 0x0000.

## Timing
- Reset values:
  - `WE`=0, `WAddr`=0, `WData`=0.
  - `Gabim`=0, `Nr_Shkrimeve`=0.
  - State `IDLE`, so `Ready`=1 in the first cycle after reset.
- Latency: transfer at edge N produces the write strobe visible after edge N; the register file samples it at edge N+1. For a product, the high-half write follows exactly one cycle after the low-half write.
- Throughput:
  - Non-multiply results: 1 per cycle.
  - Multiply results: 1 per 2 cycles. `Ready`=0 for exactly one cycle after each accepted product.
- `Ready` is a combinational decode of state only. It never depends on `Valid`.
- Reset asserted while in `WR_HI`: the pending high write is dropped, `WE`=0 next cycle, and state returns to `IDLE`.
- Reset has priority over every transfer on the same edge.

## Test plan
- **Reset:** Assert `Reset` 2 cycles with `Valid`=1 -> `WE`=0, `Ready`=1, `Gabim`=0, `Nr_Shkrimeve`=0 throughout.
- **Back-to-back ALU writes:** `S`=000, `RD`=3, ALU=0x123456, followed next cycle by `S`=110, `RD`=4, ALU=0xABCDEF -> consecutive strobes (3, 0x123456) then (4, 0xABCDEF). `Ready` stays 1. `Nr_Shkrimeve`=2.
- **Multiply split:** `S`=100, `RD`=6, MUL=0x0000FF_FFFF01 -> (6, 0xFFFF01) then (7, 0x0000FF). `Ready`=0 for exactly one cycle. A `Valid` ALU op held during that cycle is written the cycle after the high half.
- **Wrap:** `S`=100, `RD`=15, MUL=0x111111_222222 -> (15, 0x222222) then (0, 0x111111).
- **Illegal select and no-write:** `S`=111 -> no `WE`, `Gabim`=1 and stays 1 after later legal ops. `RegWrite`=0 with `S`=100 -> no `WE`, `Ready` stays 1.
- **Reset mid-product:** accept `S`=100, then assert `Reset` in the `WR_HI` cycle -> only the low write appears, `Ready`=1 after reset, counter=0.
